// File: rtl/decap_rci_lkup.sv
// RCI lookup: hash one key into two cuckoo tables, compare all bucket entries, fetch the value row on a hit.
// Optional hit/miss statistics counters are enabled by defining DECAP_RCI_LKUP_STATS_EN.
module decap_rci_lkup #(
  parameter int KEY_NBITS         = 32,
  parameter int DEPTH_NBITS       = 10,
  parameter int VALUE_DEPTH_NBITS = 10,
  parameter int VALUE_NBITS       = 300,
  parameter int ENTRIES           = 2,
  localparam int BUCKET_NBITS     = ENTRIES * (1 + KEY_NBITS + VALUE_DEPTH_NBITS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef DECAP_RCI_LKUP_STATS_EN
  input  logic                         stat_clr,
  output logic [31:0]                  stat_hit_cnt,
  output logic [31:0]                  stat_miss_cnt,
`endif
  input  logic                         lkup_req,
  input  logic [KEY_NBITS-1:0]         lkup_key,
  output logic                         lkup_ready,
  output logic                         rci_hash_table0_rd,
  output logic [DEPTH_NBITS-1:0]       rci_hash_table0_raddr,
  output logic                         rci_hash_table1_rd,
  output logic [DEPTH_NBITS-1:0]       rci_hash_table1_raddr,
  input  logic                         rci_hash_table0_ack,
  input  logic [BUCKET_NBITS-1:0]      rci_hash_table0_rdata,
  input  logic                         rci_hash_table1_ack,
  input  logic [BUCKET_NBITS-1:0]      rci_hash_table1_rdata,
  output logic                         rci_value_rd,
  output logic [VALUE_DEPTH_NBITS-1:0] rci_value_raddr,
  input  logic                         rci_value_ack,
  input  logic [VALUE_NBITS-1:0]       rci_value_rdata,
  output logic                         rslt_valid,
  input  logic                         rslt_ready,
  output logic                         rslt_hit,
  output logic [KEY_NBITS-1:0]         rslt_key,
  output logic [VALUE_DEPTH_NBITS-1:0] rslt_vptr,
  output logic [VALUE_NBITS-1:0]       rslt_value
);

  localparam int ENT_NBITS = 1 + KEY_NBITS + VALUE_DEPTH_NBITS;
  localparam int NCHUNK    = (KEY_NBITS + DEPTH_NBITS - 1) / DEPTH_NBITS;

  typedef enum logic [2:0] {IDLE, HT_RD, HT_WAIT, CMP, VAL_RD, VAL_WAIT, OUT} state_t;

  state_t                   state;
  logic [KEY_NBITS-1:0]     key_q;
  logic [BUCKET_NBITS-1:0]  bkt0;
  logic [BUCKET_NBITS-1:0]  bkt1;
  logic                     cap0;
  logic                     cap1;
  logic [KEY_NBITS-1:0]     key_rot;
  logic [DEPTH_NBITS-1:0]   hash0;
  logic [DEPTH_NBITS-1:0]   hash1;
  logic                     cmp_hit;
  logic [VALUE_DEPTH_NBITS-1:0] cmp_vptr;

  function automatic logic [DEPTH_NBITS-1:0] fold(input logic [KEY_NBITS-1:0] k);
    logic [NCHUNK*DEPTH_NBITS-1:0] pad;
    logic [DEPTH_NBITS-1:0]        h;
    pad = '0;
    pad[KEY_NBITS-1:0] = k;
    h = '0;
    for (int c = 0; c < NCHUNK; c++) h = h ^ pad[c*DEPTH_NBITS +: DEPTH_NBITS];
    return h;
  endfunction

  function automatic logic ent_match(input logic [ENT_NBITS-1:0] ent, input logic [KEY_NBITS-1:0] k);
    return ent[ENT_NBITS-1] && (ent[ENT_NBITS-2 -: KEY_NBITS] == k);
  endfunction

  assign key_rot = {lkup_key[KEY_NBITS-8:0], lkup_key[KEY_NBITS-1:KEY_NBITS-7]};
  assign hash0   = fold(lkup_key);
  assign hash1   = fold(key_rot);

  // Scan lowest priority first so the last match written is table0, lowest entry.
  always_comb begin
    cmp_hit  = 1'b0;
    cmp_vptr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_match(bkt1[i*ENT_NBITS +: ENT_NBITS], key_q)) begin
        cmp_hit  = 1'b1;
        cmp_vptr = bkt1[i*ENT_NBITS +: VALUE_DEPTH_NBITS];
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_match(bkt0[i*ENT_NBITS +: ENT_NBITS], key_q)) begin
        cmp_hit  = 1'b1;
        cmp_vptr = bkt0[i*ENT_NBITS +: VALUE_DEPTH_NBITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      key_q                 <= '0;
      bkt0                  <= '0;
      bkt1                  <= '0;
      cap0                  <= 1'b0;
      cap1                  <= 1'b0;
      lkup_ready            <= 1'b1;
      rci_hash_table0_rd    <= 1'b0;
      rci_hash_table0_raddr <= '0;
      rci_hash_table1_rd    <= 1'b0;
      rci_hash_table1_raddr <= '0;
      rci_value_rd          <= 1'b0;
      rci_value_raddr       <= '0;
      rslt_valid            <= 1'b0;
      rslt_hit              <= 1'b0;
      rslt_key              <= '0;
      rslt_vptr             <= '0;
      rslt_value            <= '0;
    end else begin
      case (state)
        IDLE: if (lkup_req) begin
          key_q                 <= lkup_key;
          rci_hash_table0_raddr <= hash0;
          rci_hash_table1_raddr <= hash1;
          rci_hash_table0_rd    <= 1'b1;
          rci_hash_table1_rd    <= 1'b1;
          cap0                  <= 1'b0;
          cap1                  <= 1'b0;
          lkup_ready            <= 1'b0;
          state                 <= HT_RD;
        end
        HT_RD: begin
          rci_hash_table0_rd <= 1'b0;
          rci_hash_table1_rd <= 1'b0;
          state              <= HT_WAIT;
        end
        HT_WAIT: begin
          // First ack per table wins; repeats are dropped.
          if (rci_hash_table0_ack && !cap0) begin
            bkt0 <= rci_hash_table0_rdata;
            cap0 <= 1'b1;
          end
          if (rci_hash_table1_ack && !cap1) begin
            bkt1 <= rci_hash_table1_rdata;
            cap1 <= 1'b1;
          end
          if ((cap0 || rci_hash_table0_ack) && (cap1 || rci_hash_table1_ack)) state <= CMP;
        end
        CMP: begin
          if (cmp_hit) begin
            rci_value_rd    <= 1'b1;
            rci_value_raddr <= cmp_vptr;
            state           <= VAL_RD;
          end else begin
            rslt_valid <= 1'b1;
            rslt_hit   <= 1'b0;
            rslt_key   <= key_q;
            rslt_vptr  <= '0;
            rslt_value <= '0;
            state      <= OUT;
          end
        end
        VAL_RD: begin
          rci_value_rd <= 1'b0;
          state        <= VAL_WAIT;
        end
        VAL_WAIT: if (rci_value_ack) begin
          rslt_valid <= 1'b1;
          rslt_hit   <= 1'b1;
          rslt_key   <= key_q;
          rslt_vptr  <= rci_value_raddr;
          rslt_value <= rci_value_rdata;
          state      <= OUT;
        end
        OUT: if (rslt_ready) begin
          rslt_valid <= 1'b0;
          lkup_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DECAP_RCI_LKUP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (stat_clr) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (rslt_valid && rslt_ready) begin
      if (rslt_hit) begin
        if (stat_hit_cnt != 32'hFFFF_FFFF) stat_hit_cnt <= stat_hit_cnt + 32'd1;
      end else begin
        if (stat_miss_cnt != 32'hFFFF_FFFF) stat_miss_cnt <= stat_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
